// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver
// SPI-slave model of the SSD1306 controller side of the 4-wire display bus.
// Assembles SPI mode-0 bytes, decodes the command stream (addressing mode,
// column/page windows, display on/off) and turns data bytes into one-cycle
// write strobes into an external 128x64 frame RAM at address {page, col}.
// Optional macro SSD1306_RX_CMD_TRACE_EN adds o_Cmd_DV / o_Cmd_Byte, which
// present every received command-stream byte at the same latency as o_Wr_En.

module ssd1306_spi_receiver #(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_MOSI,
    input  logic       i_SPI_CS_n,
    input  logic       i_DC,
    output logic       o_Wr_En,
    output logic [9:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Display_On,
`ifdef SSD1306_RX_CMD_TRACE_EN
    output logic       o_Cmd_DV,
    output logic [7:0] o_Cmd_Byte,
`endif
    output logic       o_Frame_Done
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [PW-1:0] PAGE_ONE = PW'(1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2,
        ST_SKIP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and SCLK rise detection
    // ------------------------------------------------------------------
    logic [1:0] sclk_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic [1:0] cs_sync_reg;
    logic [1:0] dc_sync_reg;
    logic       sclk_prev_reg;
    logic       sclk_rise;

    // Two-flop synchronisers for every SPI pin plus a delayed SCLK copy.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync_reg <= 2'b00;
            mosi_sync_reg <= 2'b00;
            cs_sync_reg   <= 2'b11;
            dc_sync_reg   <= 2'b00;
            sclk_prev_reg <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], i_SPI_Clk};
            mosi_sync_reg <= {mosi_sync_reg[0], i_SPI_MOSI};
            cs_sync_reg   <= {cs_sync_reg[0], i_SPI_CS_n};
            dc_sync_reg   <= {dc_sync_reg[0], i_DC};
            sclk_prev_reg <= sclk_sync_reg[1];
        end
    end

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic [6:0] shift_reg;
    logic [7:0] byte_reg;
    logic       byte_dc_reg;
    logic       byte_dv_reg;

    // Shift MOSI in MSB first; CS high throws away a partial byte.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 7'd0;
            byte_reg    <= 8'd0;
            byte_dc_reg <= 1'b0;
            byte_dv_reg <= 1'b0;
        end else begin
            byte_dv_reg <= 1'b0;
            if (cs_sync_reg[1]) begin
                bit_cnt_reg <= 3'd0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[5:0], mosi_sync_reg[1]};
                if (bit_cnt_reg == 3'd7) begin
                    byte_reg    <= {shift_reg, mosi_sync_reg[1]};
                    byte_dc_reg <= dc_sync_reg[1];
                    byte_dv_reg <= 1'b1;
                    bit_cnt_reg <= 3'd0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Command parser and write pointer
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [7:0]      op_reg, op_next;
    logic [6:0]      arg1_reg, arg1_next;
    logic [2:0]      skip_cnt_reg, skip_cnt_next;
    logic [1:0]      mode_reg, mode_next;
    logic [CW-1:0]   col_start_reg, col_start_next;
    logic [CW-1:0]   col_end_reg, col_end_next;
    logic [PW-1:0]   page_start_reg, page_start_next;
    logic [PW-1:0]   page_end_reg, page_end_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [PW-1:0]   page_reg, page_next;
    logic            display_on_reg, display_on_next;
    logic            wr_en_reg, wr_en_next;
    logic [9:0]      wr_addr_reg, wr_addr_next;
    logic [7:0]      wr_data_reg, wr_data_next;
    logic            frame_done_reg, frame_done_next;

    // Parser state and every piece of register state it owns.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_reg      <= ST_IDLE;
            op_reg         <= 8'd0;
            arg1_reg       <= 7'd0;
            skip_cnt_reg   <= 3'd0;
            mode_reg       <= 2'b00;
            col_start_reg  <= '0;
            col_end_reg    <= COL_LAST;
            page_start_reg <= '0;
            page_end_reg   <= PAGE_LAST;
            col_reg        <= '0;
            page_reg       <= '0;
            display_on_reg <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= 10'd0;
            wr_data_reg    <= 8'd0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            arg1_reg       <= arg1_next;
            skip_cnt_reg   <= skip_cnt_next;
            mode_reg       <= mode_next;
            col_start_reg  <= col_start_next;
            col_end_reg    <= col_end_next;
            page_start_reg <= page_start_next;
            page_end_reg   <= page_end_next;
            col_reg        <= col_next;
            page_reg       <= page_next;
            display_on_reg <= display_on_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Decode each completed byte: data writes and advances, commands steer the FSM.
    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        arg1_next       = arg1_reg;
        skip_cnt_next   = skip_cnt_reg;
        mode_next       = mode_reg;
        col_start_next  = col_start_reg;
        col_end_next    = col_end_reg;
        page_start_next = page_start_reg;
        page_end_next   = page_end_reg;
        col_next        = col_reg;
        page_next       = page_reg;
        display_on_next = display_on_reg;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        frame_done_next = 1'b0;

        if (byte_dv_reg) begin
            if (byte_dc_reg) begin
                // Data always wins: abandon any pending parameters and write.
                state_next   = ST_IDLE;
                wr_en_next   = 1'b1;
                wr_addr_next = {page_reg, col_reg};
                wr_data_next = byte_reg;
                case (mode_reg)
                    2'b01: begin
                        if (page_reg == page_end_reg) begin
                            page_next = page_start_reg;
                            if (col_reg == col_end_reg) begin
                                col_next        = col_start_reg;
                                frame_done_next = 1'b1;
                            end else begin
                                col_next = col_reg + COL_ONE;
                            end
                        end else begin
                            page_next = page_reg + PAGE_ONE;
                        end
                    end
                    2'b10: begin
                        col_next = col_reg + COL_ONE;
                    end
                    default: begin
                        if (col_reg == col_end_reg) begin
                            col_next = col_start_reg;
                            if (page_reg == page_end_reg) begin
                                page_next       = page_start_reg;
                                frame_done_next = 1'b1;
                            end else begin
                                page_next = page_reg + PAGE_ONE;
                            end
                        end else begin
                            col_next = col_reg + COL_ONE;
                        end
                    end
                endcase
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        op_next = byte_reg;
                        if (byte_reg[7:4] == 4'h0) begin
                            col_next[3:0] = byte_reg[3:0];
                        end else if (byte_reg[7:3] == 5'b00010) begin
                            col_next[6:4] = byte_reg[2:0];
                        end else if (byte_reg[7:3] == 5'b10110) begin
                            page_next = byte_reg[2:0];
                        end else begin
                            case (byte_reg)
                                8'h20, 8'h21, 8'h22: state_next = ST_ARG1;
                                8'hAE: display_on_next = 1'b0;
                                8'hAF: display_on_next = 1'b1;
                                8'h81, 8'h8D, 8'hA8, 8'hD3,
                                8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                                    skip_cnt_next = 3'd1;
                                    state_next    = ST_SKIP;
                                end
                                8'hA3: begin
                                    skip_cnt_next = 3'd2;
                                    state_next    = ST_SKIP;
                                end
                                8'h29, 8'h2A: begin
                                    skip_cnt_next = 3'd5;
                                    state_next    = ST_SKIP;
                                end
                                8'h26, 8'h27: begin
                                    skip_cnt_next = 3'd6;
                                    state_next    = ST_SKIP;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_ARG1: begin
                        if (op_reg == 8'h20) begin
                            // Mode 11 is reserved; fall back to horizontal.
                            mode_next  = (byte_reg[1:0] == 2'b11) ? 2'b00 : byte_reg[1:0];
                            state_next = ST_IDLE;
                        end else begin
                            arg1_next  = byte_reg[6:0];
                            state_next = ST_ARG2;
                        end
                    end
                    ST_ARG2: begin
                        if (op_reg == 8'h21) begin
                            col_start_next = arg1_reg;
                            col_end_next   = byte_reg[6:0];
                            col_next       = arg1_reg;
                        end else begin
                            page_start_next = arg1_reg[2:0];
                            page_end_next   = byte_reg[2:0];
                            page_next       = arg1_reg[2:0];
                        end
                        state_next = ST_IDLE;
                    end
                    default: begin
                        if (skip_cnt_reg <= 3'd1) begin
                            state_next = ST_IDLE;
                        end
                        skip_cnt_next = skip_cnt_reg - 3'd1;
                    end
                endcase
            end
        end
    end

    assign o_Wr_En      = wr_en_reg;
    assign o_Wr_Addr    = wr_addr_reg;
    assign o_Wr_Data    = wr_data_reg;
    assign o_Display_On = display_on_reg;
    assign o_Frame_Done = frame_done_reg;

`ifdef SSD1306_RX_CMD_TRACE_EN
    logic       cmd_dv_reg;
    logic [7:0] cmd_byte_reg;

    // Mirror every command-stream byte, aligned with the write strobe timing.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cmd_dv_reg   <= 1'b0;
            cmd_byte_reg <= 8'd0;
        end else begin
            cmd_dv_reg <= byte_dv_reg & ~byte_dc_reg;
            if (byte_dv_reg && !byte_dc_reg) begin
                cmd_byte_reg <= byte_reg;
            end
        end
    end

    assign o_Cmd_DV   = cmd_dv_reg;
    assign o_Cmd_Byte = cmd_byte_reg;
`endif

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Testbench for ssd1306_spi_receiver: table of SPI bytes with expected write
// strobes, plus hand sequences for a CS-aborted byte and mid-command reset.

module tb_ssd1306_spi_receiver;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       dc;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       disp_on;
    logic       frame_done;
`ifdef SSD1306_RX_CMD_TRACE_EN
    logic       cmd_dv;
    logic [7:0] cmd_byte;
`endif

    ssd1306_spi_receiver dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_SPI_Clk    (sclk),
        .i_SPI_MOSI   (mosi),
        .i_SPI_CS_n   (cs_n),
        .i_DC         (dc),
        .o_Wr_En      (wr_en),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_Data    (wr_data),
        .o_Display_On (disp_on),
`ifdef SSD1306_RX_CMD_TRACE_EN
        .o_Cmd_DV     (cmd_dv),
        .o_Cmd_Byte   (cmd_byte),
`endif
        .o_Frame_Done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         is_data;
        logic [7:0] val;
        logic [9:0] exp_addr;
        bit         exp_fd;
        bit         exp_disp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    logic       obs_early;
    logic       obs_wr;
    logic [9:0] obs_addr;
    logic [7:0] obs_data;
    logic       obs_fd;
    logic       obs_disp;
    logic       obs_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit d, input logic [7:0] v,
                       input logic [9:0] a, input bit fd, input bit disp);
        vec_t e;
        e.rst = r; e.is_data = d; e.val = v; e.exp_addr = a; e.exp_fd = fd; e.exp_disp = disp;
        vecs.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check("reset_state", {22'd0, wr_en, wr_addr, wr_data, disp_on, frame_done}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    // Send nbits of b MSB first; the 8th rise samples outputs 3, 4 and 5 cycles later.
    task automatic send_bits(input logic d, input logic [7:0] b, input int nbits);
        logic [7:0] sh;
        sh = b;
        dc = d;
        for (int i = 0; i < nbits; i++) begin
            mosi = sh[7];
            sh   = {sh[6:0], 1'b0};
            repeat (4) tick();
            sclk = 1'b1;
            if (i == 7) begin
                repeat (3) tick();
                obs_early = wr_en;
                tick();
                obs_wr   = wr_en;
                obs_addr = wr_addr;
                obs_data = wr_data;
                obs_fd   = frame_done;
                obs_disp = disp_on;
                tick();
                obs_after = wr_en;
                sclk = 1'b0;
            end else begin
                repeat (4) tick();
                sclk = 1'b0;
            end
        end
        repeat (2) tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sclk  = 1'b0;
        mosi  = 1'b0;
        cs_n  = 1'b1;
        dc    = 1'b0;

        // Plain data after reset.
        add(1, 1, 8'h55, 10'd0, 0, 0);
        add(0, 1, 8'hAA, 10'd1, 0, 0);
        // Window col 126..127, page 6..7.
        add(0, 0, 8'h21, 10'd0, 0, 0);
        add(0, 0, 8'h7E, 10'd0, 0, 0);
        add(0, 0, 8'h7F, 10'd0, 0, 0);
        add(0, 0, 8'h22, 10'd0, 0, 0);
        add(0, 0, 8'h06, 10'd0, 0, 0);
        add(0, 0, 8'h07, 10'd0, 0, 0);
        add(0, 1, 8'h01, 10'd894, 0, 0);
        add(0, 1, 8'h02, 10'd895, 0, 0);
        add(0, 1, 8'h03, 10'd1022, 0, 0);
        add(0, 1, 8'h04, 10'd1023, 1, 0);
        add(0, 1, 8'h05, 10'd894, 0, 0);
        // Vertical mode over full window.
        add(1, 0, 8'h20, 10'd0, 0, 0);
        add(0, 0, 8'h01, 10'd0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 8'(8'h10 + i), 10'(i * 128), 0, 0);
        add(0, 1, 8'h18, 10'd1, 0, 0);
        // Page mode, page 3, col 0x75, column wraps without frame pulse.
        add(1, 0, 8'h20, 10'd0, 0, 0);
        add(0, 0, 8'h02, 10'd0, 0, 0);
        add(0, 0, 8'hB3, 10'd0, 0, 0);
        add(0, 0, 8'h05, 10'd0, 0, 0);
        add(0, 0, 8'h17, 10'd0, 0, 0);
        for (int i = 0; i < 11; i++) add(0, 1, 8'(8'hC0 + i), 10'(501 + i), 0, 0);
        add(0, 1, 8'hCB, 10'd384, 0, 0);
        // Skipped contrast parameter, display on, windows untouched.
        add(1, 0, 8'h81, 10'd0, 0, 0);
        add(0, 0, 8'h21, 10'd0, 0, 0);
        add(0, 0, 8'hAF, 10'd0, 0, 1);
        add(0, 1, 8'h3C, 10'd0, 0, 1);
        add(0, 1, 8'h3D, 10'd1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                cs_n = 1'b1;
                do_reset();
                cs_n = 1'b0;
                repeat (4) tick();
            end
            send_bits(vecs[i].is_data, vecs[i].val, 8);
            check($sformatf("v%0d_latency_early", i), {31'd0, obs_early}, 32'd0);
            check($sformatf("v%0d_wr_en", i), {31'd0, obs_wr}, {31'd0, vecs[i].is_data});
            check($sformatf("v%0d_wr_pulse_len", i), {31'd0, obs_after}, 32'd0);
            check($sformatf("v%0d_display_on", i), {31'd0, obs_disp}, {31'd0, vecs[i].exp_disp});
            if (vecs[i].is_data) begin
                check($sformatf("v%0d_addr", i), {22'd0, obs_addr}, {22'd0, vecs[i].exp_addr});
                check($sformatf("v%0d_data", i), {24'd0, obs_data}, {24'd0, vecs[i].val});
                check($sformatf("v%0d_frame_done", i), {31'd0, obs_fd}, {31'd0, vecs[i].exp_fd});
            end
            $display("vec %0d dc=%0d byte=%02h wr=%0d addr=%0d data=%02h fd=%0d disp=%0d",
                     i, vecs[i].is_data, vecs[i].val, obs_wr, obs_addr, obs_data, obs_fd, obs_disp);
        end

        // Partial 0xAE aborted by CS, then a full 0xAE turns the display off.
        send_bits(1'b0, 8'hAE, 5);
        cs_n = 1'b1;
        repeat (6) tick();
        cs_n = 1'b0;
        repeat (4) tick();
        send_bits(1'b0, 8'hAE, 8);
        check("cs_abort_display_off", {31'd0, obs_disp}, 32'd0);
        check("cs_abort_no_write", {31'd0, obs_wr}, 32'd0);
        $display("cs abort: disp=%0d wr=%0d", obs_disp, obs_wr);

        // Reset between the two parameters of 0x21: next byte parsed as opcode.
        cs_n = 1'b1;
        do_reset();
        cs_n = 1'b0;
        repeat (4) tick();
        send_bits(1'b0, 8'h21, 8);
        send_bits(1'b0, 8'h05, 8);
        do_reset();
        send_bits(1'b0, 8'hAF, 8);
        check("rst_mid_param_opcode", {31'd0, obs_disp}, 32'd1);
        send_bits(1'b1, 8'h99, 8);
        check("rst_mid_param_wr", {31'd0, obs_wr}, 32'd1);
        check("rst_mid_param_addr", {22'd0, obs_addr}, 32'd0);
        check("rst_mid_param_data", {24'd0, obs_data}, 32'h99);
        $display("reset mid-param: wr=%0d addr=%0d data=%02h", obs_wr, obs_addr, obs_data);
        // Full-width window restored: pointer continues to column 1.
        send_bits(1'b1, 8'h9A, 8);
        check("rst_mid_param_next_addr", {22'd0, obs_addr}, 32'd1);
        $display("after reset next write: addr=%0d", obs_addr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
